// File: rtl/execute_stage.sv
// execute_stage: X stage with M/W operand forwarding, ALU, branch resolve and the X/M pipeline register
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_value,
    input  logic [31:0] read_data_0,
    input  logic [31:0] read_data_1,
    input  logic [31:0] immediate,
    input  logic [2:0]  alu_op,
    input  logic        alu_src,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_reg,
    input  logic        reg_dst,
    input  logic        branch,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic        mw_reg_write,
    input  logic [4:0]  mw_write_addr,
    input  logic [31:0] mw_write_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] alu_result_buffered,
    output logic [31:0] store_data_buffered,
    output logic [4:0]  write_addr_buffered,
    output logic        mem_read_buffered,
    output logic        mem_write_buffered,
    output logic        reg_write_buffered,
    output logic        mem_reg_buffered,
    output logic        branch_taken_buffered,
    output logic [31:0] branch_target_buffered
);
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  wa;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        mreg;
        logic        bt;
        logic [31:0] tgt;
    } xm_t;

    xm_t         xm_q, xm_d;
    logic [31:0] fwd_a, fwd_b, op_b, alu_res;
    logic        m_hit_a, m_hit_b, w_hit_a, w_hit_b;

    // operand forwarding: an ALU result in M beats W, which beats the register file; r0 and loads never forward
    always_comb begin
        m_hit_a = xm_q.rw && !xm_q.mr && xm_q.wa != 5'd0 && xm_q.wa == rs_addr;
        m_hit_b = xm_q.rw && !xm_q.mr && xm_q.wa != 5'd0 && xm_q.wa == rt_addr;
        w_hit_a = mw_reg_write && mw_write_addr != 5'd0 && mw_write_addr == rs_addr;
        w_hit_b = mw_reg_write && mw_write_addr != 5'd0 && mw_write_addr == rt_addr;
        fwd_a   = m_hit_a ? xm_q.alu : w_hit_a ? mw_write_data : read_data_0;
        fwd_b   = m_hit_b ? xm_q.alu : w_hit_b ? mw_write_data : read_data_1;
        op_b    = alu_src ? immediate : fwd_b;
    end

    // ALU with wrapping add/sub and signed set-less-than
    always_comb begin
        case (alu_op)
            3'd0:    alu_res = fwd_a + op_b;
            3'd2:    alu_res = fwd_a - op_b;
            3'd3:    alu_res = fwd_a & op_b;
            3'd4:    alu_res = fwd_a | op_b;
            3'd5:    alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            3'd6:    alu_res = fwd_a ^ op_b;
            3'd7:    alu_res = ~(fwd_a | op_b);
            default: alu_res = 32'd0;
        endcase
    end

    // next X/M contents; branch compares the forwarded registers, never the immediate
    always_comb begin
        xm_d      = '0;
        xm_d.alu  = alu_res;
        xm_d.sd   = fwd_b;
        xm_d.wa   = reg_dst ? rd_addr : rt_addr;
        xm_d.mr   = mem_read;
        xm_d.mw   = mem_write;
        xm_d.rw   = reg_write;
        xm_d.mreg = mem_reg;
        xm_d.bt   = branch && fwd_a == fwd_b;
        xm_d.tgt  = pc_value + {immediate[29:0], 2'b00};
    end

    // X/M register: reset and flush both insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (rst || flush)
            xm_q <= '0;
        else if (!stall)
            xm_q <= xm_d;
    end

    assign alu_result_buffered    = xm_q.alu;
    assign store_data_buffered    = xm_q.sd;
    assign write_addr_buffered    = xm_q.wa;
    assign mem_read_buffered      = xm_q.mr;
    assign mem_write_buffered     = xm_q.mw;
    assign reg_write_buffered     = xm_q.rw;
    assign mem_reg_buffered       = xm_q.mreg;
    assign branch_taken_buffered  = xm_q.bt;
    assign branch_target_buffered = xm_q.tgt;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random checks of execute_stage against a behavioural model
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, alu_src, mem_read, mem_write, reg_write, mem_reg, reg_dst, branch;
    logic        mw_reg_write, stall, flush;
    logic [31:0] pc_value, read_data_0, read_data_1, immediate, mw_write_data;
    logic [2:0]  alu_op;
    logic [4:0]  rs_addr, rt_addr, rd_addr, mw_write_addr;
    logic [31:0] alu_result_buffered, store_data_buffered, branch_target_buffered;
    logic [4:0]  write_addr_buffered;
    logic        mem_read_buffered, mem_write_buffered, reg_write_buffered, mem_reg_buffered;
    logic        branch_taken_buffered;

    typedef struct packed {
        logic [31:0] alu, sd, tgt;
        logic [4:0]  wa;
        logic        mr, mw, rw, mreg, bt;
    } out_t;

    out_t ex = '0;
    int   n_chk = 0, n_pass = 0;
    bit   cmp_en = 1'b0;

    execute_stage dut (
        .clk(clk), .rst(rst), .pc_value(pc_value), .read_data_0(read_data_0),
        .read_data_1(read_data_1), .immediate(immediate), .alu_op(alu_op), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_reg(mem_reg),
        .reg_dst(reg_dst), .branch(branch), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .mw_reg_write(mw_reg_write), .mw_write_addr(mw_write_addr),
        .mw_write_data(mw_write_data), .stall(stall), .flush(flush),
        .alu_result_buffered(alu_result_buffered), .store_data_buffered(store_data_buffered),
        .write_addr_buffered(write_addr_buffered), .mem_read_buffered(mem_read_buffered),
        .mem_write_buffered(mem_write_buffered), .reg_write_buffered(reg_write_buffered),
        .mem_reg_buffered(mem_reg_buffered), .branch_taken_buffered(branch_taken_buffered),
        .branch_target_buffered(branch_target_buffered)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // value a register read must see: the instruction now in M (if a non-load writing it), else W, else the file
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (ex.rw && !ex.mr && ex.wa == r) return ex.alu;
        if (mw_reg_write && mw_write_addr == r) return mw_write_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a ^ b;
            3'd7: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic out_t model_next();
        out_t r;
        logic [31:0] a, b;
        r = '0;
        if (rst || flush) return r;
        if (stall) return ex;
        a      = reg_value(rs_addr, read_data_0);
        b      = reg_value(rt_addr, read_data_1);
        r.alu  = alu_ref(alu_op, a, alu_src ? immediate : b);
        r.sd   = b;
        r.wa   = reg_dst ? rd_addr : rt_addr;
        r.mr   = mem_read;
        r.mw   = mem_write;
        r.rw   = reg_write;
        r.mreg = mem_reg;
        r.bt   = branch && (a == b);
        r.tgt  = pc_value + immediate * 4;
        return r;
    endfunction

    task automatic step();
        out_t n;
        n = model_next();
        @(posedge clk);
        ex = n;
        #1;
    endtask

    task automatic clear_inputs();
        {rst, alu_src, mem_read, mem_write, reg_write, mem_reg, reg_dst, branch} = '0;
        {mw_reg_write, stall, flush} = '0;
        {pc_value, read_data_0, read_data_1, immediate, mw_write_data} = '0;
        alu_op = 3'd0;
        {rs_addr, rt_addr, rd_addr, mw_write_addr} = '0;
    endtask

    // literal expectation checked against both the DUT and the model
    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
        chk({name, "_dut"}, act, exp);
        chk({name, "_model"}, mdl, exp);
    endtask

    // every cycle: all registered outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("alu_result", alu_result_buffered, ex.alu);
            chk("store_data", store_data_buffered, ex.sd);
            chk("write_addr", {27'd0, write_addr_buffered}, {27'd0, ex.wa});
            chk("mem_read", {31'd0, mem_read_buffered}, {31'd0, ex.mr});
            chk("mem_write", {31'd0, mem_write_buffered}, {31'd0, ex.mw});
            chk("reg_write", {31'd0, reg_write_buffered}, {31'd0, ex.rw});
            chk("mem_reg", {31'd0, mem_reg_buffered}, {31'd0, ex.mreg});
            chk("branch_taken", {31'd0, branch_taken_buffered}, {31'd0, ex.bt});
            chk("branch_target", branch_target_buffered, ex.tgt);
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        pin("reset_alu", alu_result_buffered, ex.alu, 32'd0);
        rst = 1'b0;
        rs_addr = 5'd1; rt_addr = 5'd2; read_data_0 = 32'd10; read_data_1 = 32'hFFFFFFFF;
        step();
        pin("add_wrap", alu_result_buffered, ex.alu, 32'd9);
        alu_op = 3'd5;
        step();
        pin("slt_signed", alu_result_buffered, ex.alu, 32'd0);
        clear_inputs();
        alu_src = 1'b1; immediate = 32'd7; reg_write = 1'b1; reg_dst = 1'b1; rd_addr = 5'd3;
        step();
        pin("write_r3", alu_result_buffered, ex.alu, 32'd7);
        clear_inputs();
        rs_addr = 5'd3; mw_reg_write = 1'b1; mw_write_addr = 5'd3; mw_write_data = 32'd5;
        step();
        pin("m_beats_w", alu_result_buffered, ex.alu, 32'd7);
        clear_inputs();
        mem_read = 1'b1; reg_write = 1'b1; rt_addr = 5'd4; alu_src = 1'b1; immediate = 32'd100;
        step();
        clear_inputs();
        rs_addr = 5'd4; mw_reg_write = 1'b1; mw_write_addr = 5'd4; mw_write_data = 32'd9;
        reg_write = 1'b1; reg_dst = 1'b1;
        step();
        pin("load_not_fwd", alu_result_buffered, ex.alu, 32'd9);
        clear_inputs();
        read_data_0 = 32'd55; mw_reg_write = 1'b1; mw_write_data = 32'd77;
        step();
        pin("r0_never_fwd", alu_result_buffered, ex.alu, 32'd55);
        clear_inputs();
        branch = 1'b1; pc_value = 32'h100; immediate = 32'hFFFFFFFF; alu_src = 1'b1; alu_op = 3'd2;
        rs_addr = 5'd1; rt_addr = 5'd2; read_data_0 = 32'd5; read_data_1 = 32'd5;
        step();
        pin("beq_taken", {31'd0, branch_taken_buffered}, {31'd0, ex.bt}, 32'd1);
        pin("beq_target", branch_target_buffered, ex.tgt, 32'hFC);
        read_data_1 = 32'd6;
        step();
        pin("beq_not_taken", {31'd0, branch_taken_buffered}, {31'd0, ex.bt}, 32'd0);
        pin("beq_target2", branch_target_buffered, ex.tgt, 32'hFC);
        clear_inputs();
        rs_addr = 5'd1; rt_addr = 5'd2; read_data_0 = 32'd3; read_data_1 = 32'd4;
        reg_write = 1'b1; reg_dst = 1'b1; rd_addr = 5'd5;
        step();
        read_data_0 = 32'd100; stall = 1'b1;
        step();
        pin("stall1", alu_result_buffered, ex.alu, 32'd7);
        step();
        pin("stall2", alu_result_buffered, ex.alu, 32'd7);
        pin("stall_wa", {27'd0, write_addr_buffered}, {27'd0, ex.wa}, 32'd5);
        flush = 1'b1;
        step();
        pin("flush_alu", alu_result_buffered, ex.alu, 32'd0);
        pin("flush_rw", {31'd0, reg_write_buffered}, {31'd0, ex.rw}, 32'd0);
        flush = 1'b0; stall = 1'b0;
        step();
        rst = 1'b1; flush = 1'b1;
        step();
        pin("rst_flush", alu_result_buffered, ex.alu, 32'd0);
        for (int i = 0; i < 600; i++) begin
            rs_addr = 5'($urandom_range(0, 3));
            rt_addr = 5'($urandom_range(0, 3));
            rd_addr = 5'($urandom_range(0, 3));
            mw_write_addr = 5'($urandom_range(0, 3));
            read_data_0 = $urandom;
            read_data_1 = ($urandom_range(0, 3) == 0) ? read_data_0 : $urandom;
            immediate = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
            pc_value = $urandom;
            mw_write_data = $urandom;
            alu_op = 3'($urandom_range(0, 7));
            {alu_src, mem_read, mem_write, reg_write, mem_reg, reg_dst, branch, mw_reg_write} = 8'($urandom);
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 31) == 0;
            step();
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high; sampled on rising clk.
REQ-003 pc_value  in  32  PC+4 of the instruction in X.
REQ-004 read_data_0, read_data_1  in  32 each  register-file operands A (rs) and B (rt).
REQ-005 immediate  in  32  sign-extended immediate.
REQ-006 alu_op  in  3  ALU select, encoded per REQ-021.
REQ-007 alu_src  in  1  1 = operand B is immediate, 0 = forwarded rt.
REQ-008 mem_read, mem_write, reg_write, mem_reg, reg_dst, branch  in  1 each  decoded control.
REQ-009 rs_addr, rt_addr, rd_addr  in  5 each  register specifiers.
REQ-010 mw_reg_write  in  1  W stage will write the register file.
REQ-011 mw_write_addr  in  5  W-stage destination.
REQ-012 mw_write_data  in  32  W-stage writeback value.
REQ-013 stall  in  1  hold all X/M outputs.
REQ-014 flush  in  1  load a bubble into X/M.
REQ-015 alu_result_buffered  out  32  registered ALU result.
REQ-016 store_data_buffered  out  32  registered forwarded rt value.
REQ-017 write_addr_buffered  out  5  registered destination register.
REQ-018 mem_read_buffered, mem_write_buffered, reg_write_buffered, mem_reg_buffered  out  1 each  registered control.
REQ-019 branch_taken_buffered  out  1  registered branch decision.
REQ-020 branch_target_buffered  out  32  registered branch target.

Function
REQ-021 ALU: 0 ADD, 1 NOP (result 32'h0), 2 SUB, 3 AND, 4 OR, 5 SLT (signed, result 0 or 1), 6 XOR, 7 NOR; ADD/SUB wrap modulo 2^32, no overflow flag.
REQ-022 Forward A (rs) and B (rt) independently, in priority order: M source, then W source, then register file.
REQ-023 M source is valid when reg_write_buffered=1, mem_read_buffered=0, write_addr_buffered!=0 and it equals the specifier; the forwarded value is alu_result_buffered.
REQ-024 W source is valid when mw_reg_write=1, mw_write_addr!=0 and it equals the specifier; the forwarded value is mw_write_data.
REQ-025 Register 0 is never forwarded; a load in M is never forwarded (the stall is owned by the hazard unit).
REQ-026 Operand B to the ALU is immediate when alu_src=1, else forwarded rt; store data is always forwarded rt.
REQ-027 Destination: write_addr = rd_addr when reg_dst=1, else rt_addr.
REQ-028 Branch: taken when branch=1 and forwarded A == forwarded B; target = pc_value + (immediate << 2), modulo 2^32; target is computed regardless of branch.
REQ-029 Latency: one cycle; X inputs sampled at edge N appear on outputs after edge N.
REQ-030 Priority each edge: rst > flush > stall > normal load.
REQ-031 flush=1: all 1-bit outputs load 0, data/address outputs load 0, regardless of stall.
REQ-032 stall=1, flush=0: all outputs hold their previous values; forwarding still uses the held M values.
REQ-033 Forwarding, ALU and branch logic are combinational from inputs and registered outputs; no other internal state.

Reset
REQ-034 rst=1 at a rising edge: every output loads 0 (branch_taken_buffered=0, reg_write_buffered=0, mem_write_buffered=0), overriding stall and flush.
REQ-035 Reset asserted mid-stream discards the in-flight X instruction; the first post-reset edge with rst=0 loads normally.

Verification
REQ-036 ADD, rs=1 (10), rt=2 (32'hFFFFFFFF), alu_src=0 -> alu_result_buffered=9 one cycle later; SLT on the same operands -> 0.
REQ-037 Back-to-back: first instruction writes r3=7; the next reads rs=3 with stale rf value 0 -> M forward, operand A=7; simultaneous W match on r3 with 5 -> M wins (7).
REQ-038 Prior instruction is a load to r4 in M, W writes r4=9 -> operand uses 9, not alu_result_buffered; rs=0 with M/W targeting r0 -> operand = read_data_0.
REQ-039 BEQ with pc_value=32'h100, immediate=32'hFFFFFFFF, equal operands -> branch_taken_buffered=1, branch_target_buffered=32'hFC; unequal operands -> 0 with the same target.
REQ-040 stall=1 for 2 cycles -> outputs unchanged; flush and stall together -> bubble (all 0); rst with flush -> all 0.
